// File: rtl/pong_pkg.sv
// Shared pong video definitions: render sequencer states,
// VGA source-select codes and the default phase timeout.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR_P1,
    ST_DRW_P1,
    ST_CLR_P2,
    ST_DRW_P2,
    ST_CLR_BALL,
    ST_DRW_BALL,
    ST_FIN
  } render_state_t;

  localparam logic [1:0] SRC_NONE   = 2'd0;
  localparam logic [1:0] SRC_PADDLE = 2'd1;
  localparam logic [1:0] SRC_BALL   = 2'd2;

  localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/render_sequencer_phase_timer.sv
// Per-phase watchdog: clears on phase entry, counts
// enabled cycles, flags the last allowed cycle.
module phase_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/render_sequencer.sv
// Frame draw scheduler: walks clear/draw phases for both
// paddles and the ball, with watchdog and drop accounting.
module render_sequencer
  import pong_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int DROP_W  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic              frameTick,
  input  logic              done_clear1,
  input  logic              done_draw1,
  input  logic              done_clear2,
  input  logic              done_draw2,
  input  logic              done_ball_clear,
  input  logic              done_ball_draw,
  output logic              pulse_clear1,
  output logic              pulse_draw1,
  output logic              pulse_clear2,
  output logic              pulse_draw2,
  output logic              pulse_ball_clear,
  output logic              pulse_ball_draw,
  output logic              plot,
  output logic [1:0]        src_sel,
  output logic              busy,
  output logic              frame_done,
  output logic              err_timeout,
  output logic              frame_overrun,
  output logic [DROP_W-1:0] drop_count
);

  render_state_t     r_state;
  render_state_t     w_next;
  logic              w_phase;
  logic              w_done;
  logic              w_tc;
  logic              w_adv;
  logic              w_paddle;
  logic              w_ball;
  logic              r_plot;
  logic [1:0]        r_src;
  logic              r_err;
  logic              r_ovr;
  logic [DROP_W-1:0] r_drop;

  assign w_phase = (r_state != ST_IDLE) &&
                   (r_state != ST_FIN);

  always_comb begin
    w_done = 1'b0;
    unique case (r_state)
      ST_CLR_P1:   w_done = done_clear1;
      ST_DRW_P1:   w_done = done_draw1;
      ST_CLR_P2:   w_done = done_clear2;
      ST_DRW_P2:   w_done = done_draw2;
      ST_CLR_BALL: w_done = done_ball_clear;
      ST_DRW_BALL: w_done = done_ball_draw;
      default:     w_done = 1'b0;
    endcase
  end

  // A done coinciding with terminal count is a clean advance.
  assign w_adv = enable & w_phase & (w_done | w_tc);

  phase_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .resetn(resetn),
    .i_clr (~w_phase | w_adv),
    .i_en  (enable & w_phase),
    .o_tc  (w_tc)
  );

  always_comb begin
    w_next = r_state;
    if (enable) begin
      unique case (r_state)
        ST_IDLE: if (frameTick) w_next = ST_CLR_P1;
        ST_FIN:  w_next = ST_IDLE;
        default: begin
          if (w_adv)
            w_next = render_state_t'(r_state + 3'd1);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  assign pulse_clear1     = enable & (r_state == ST_CLR_P1);
  assign pulse_draw1      = enable & (r_state == ST_DRW_P1);
  assign pulse_clear2     = enable & (r_state == ST_CLR_P2);
  assign pulse_draw2      = enable & (r_state == ST_DRW_P2);
  assign pulse_ball_clear = enable & (r_state == ST_CLR_BALL);
  assign pulse_ball_draw  = enable & (r_state == ST_DRW_BALL);

  assign w_paddle = pulse_clear1 | pulse_draw1 |
                    pulse_clear2 | pulse_draw2;
  assign w_ball   = pulse_ball_clear | pulse_ball_draw;

  // Registered to line up with the renderer's pixel outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_plot <= 1'b0;
      r_src  <= SRC_NONE;
    end else begin
      r_plot <= w_paddle | w_ball;
      if (w_paddle)
        r_src <= SRC_PADDLE;
      else if (w_ball)
        r_src <= SRC_BALL;
      else
        r_src <= SRC_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_err  <= 1'b0;
      r_ovr  <= 1'b0;
      r_drop <= '0;
    end else begin
      if (w_adv & ~w_done)
        r_err <= 1'b1;
      if (enable & frameTick & busy) begin
        r_ovr <= 1'b1;
        if (~&r_drop)
          r_drop <= r_drop + 1'b1;
      end
    end
  end

  assign busy          = (r_state != ST_IDLE);
  assign frame_done    = enable & (r_state == ST_FIN);
  assign plot          = r_plot;
  assign src_sel       = r_src;
  assign err_timeout   = r_err;
  assign frame_overrun = r_ovr;
  assign drop_count    = r_drop;

endmodule
